// File: rtl/tamagotchi_pkg.sv
`default_nettype none
// ============================================================================
// tamagotchi_pkg : estado encodings and saturating stat arithmetic
// Rev 1.0
// ============================================================================
package tamagotchi_pkg;

  localparam logic [7:0] STAT_MAX = 8'd100;

  // One-hot encodings are shared with the image controller.
  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, STAT_MAX}) ? STAT_MAX : sum[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_estados_if.sv
`default_nettype none
// ============================================================================
// controlador_estados_if : button pulses in, pet state and stats out
// Rev 1.0
// ============================================================================
interface controlador_estados_if;

  logic       btn_comer;
  logic       btn_dormir;
  logic       btn_aula;
  logic [3:0] estado;
  logic [7:0] felicidade;
  logic [7:0] fome;
  logic [7:0] sono;
  logic       tick;

  // master: button front-end / display side; slave: the state controller
  modport master (
    output btn_comer, btn_dormir, btn_aula,
    input  estado, felicidade, fome, sono, tick
  );

  modport slave (
    input  btn_comer, btn_dormir, btn_aula,
    output estado, felicidade, fome, sono, tick
  );

endinterface
`default_nettype wire

// File: rtl/controlador_estados_gerador_tick.sv
`default_nettype none
// ============================================================================
// gerador_tick : registered one-cycle pulse every TICK_CYCLES clocks
// Rev 1.0
// ============================================================================
module gerador_tick #(
  parameter int TICK_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // The pulse lands the cycle after the counter sits at its last value.
  always_comb begin
    tick_d  = (count_q == CNT_LAST);
    count_d = tick_d ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/controlador_estados.sv
`default_nettype none
// ============================================================================
// controlador_estados : pet game-state scheduler (stats, estado, death)
// Rev 1.0
// ============================================================================
module controlador_estados
  import tamagotchi_pkg::*;
#(
  parameter int TICK_CYCLES   = 12_000_000,
  parameter int INIT_STAT     = 50,
  parameter int COMENDO_TICKS = 8,
  parameter int AULA_TICKS    = 7,
  parameter int GANHO_FOME    = 5,
  parameter int GANHO_SONO    = 4,
  parameter int GANHO_FELIC   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  controlador_estados_if.slave   bus
);

  localparam int DUR_MAX = (COMENDO_TICKS > AULA_TICKS) ? COMENDO_TICKS : AULA_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  localparam logic [DUR_W-1:0] COMENDO_LAST = DUR_W'(COMENDO_TICKS);
  localparam logic [DUR_W-1:0] AULA_LAST    = DUR_W'(AULA_TICKS);
  localparam logic [7:0]       STAT_INIT    = 8'(INIT_STAT);
  localparam logic [7:0]       INC_FOME     = 8'(GANHO_FOME);
  localparam logic [7:0]       INC_SONO     = 8'(GANHO_SONO);
  localparam logic [7:0]       INC_FELIC    = 8'(GANHO_FELIC);

  logic tick;

  gerador_tick #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_gerador_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  estado_t          estado_q, estado_d;
  logic [7:0]       felic_q, felic_d;
  logic [7:0]       fome_q, fome_d;
  logic [7:0]       sono_q, sono_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] dur_inc;

  always_comb begin
    felic_d  = felic_q;
    fome_d   = fome_q;
    sono_d   = sono_q;
    estado_d = estado_q;
    dur_d    = dur_q;
    dur_inc  = dur_q + DUR_W'(1);

    // Stat update follows the rule of the state the tick arrives in.
    if (tick) begin
      unique case (estado_q)
        IDLE: begin
          fome_d  = sat_sub(fome_q, 8'd1);
          sono_d  = sat_sub(sono_q, 8'd1);
          felic_d = sat_sub(felic_q, 8'd1);
        end
        COMENDO: begin
          fome_d  = sat_add(fome_q, INC_FOME);
          felic_d = sat_add(felic_q, 8'd1);
        end
        DORMINDO: begin
          sono_d  = sat_add(sono_q, INC_SONO);
          fome_d  = sat_sub(fome_q, 8'd1);
        end
        DANDO_AULA: begin
          felic_d = sat_add(felic_q, INC_FELIC);
          fome_d  = sat_sub(fome_q, 8'd2);
          sono_d  = sat_sub(sono_q, 8'd2);
        end
        default: ;
      endcase
    end

    if (estado_q != MORTO) begin
      if (tick && (fome_d == 8'd0 || sono_d == 8'd0)) begin
        estado_d = MORTO;
      end else begin
        unique case (estado_q)
          IDLE: begin
            if (bus.btn_comer)       estado_d = COMENDO;
            else if (bus.btn_dormir) estado_d = DORMINDO;
            else if (bus.btn_aula)   estado_d = DANDO_AULA;
          end
          COMENDO: begin
            if (tick) begin
              dur_d = dur_inc;
              if (dur_inc == COMENDO_LAST) estado_d = IDLE;
            end
          end
          DANDO_AULA: begin
            if (tick) begin
              dur_d = dur_inc;
              if (dur_inc == AULA_LAST) estado_d = IDLE;
            end
          end
          DORMINDO: begin
            if ((tick && sono_d == STAT_MAX) || bus.btn_dormir) estado_d = IDLE;
          end
          default: estado_d = IDLE;
        endcase
      end
    end

    if (estado_d != estado_q) dur_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      felic_q  <= STAT_INIT;
      fome_q   <= STAT_INIT;
      sono_q   <= STAT_INIT;
      dur_q    <= '0;
    end else begin
      estado_q <= estado_d;
      felic_q  <= felic_d;
      fome_q   <= fome_d;
      sono_q   <= sono_d;
      dur_q    <= dur_d;
    end
  end

  assign bus.estado     = estado_q;
  assign bus.felicidade = felic_q;
  assign bus.fome       = fome_q;
  assign bus.sono       = sono_q;
  assign bus.tick       = tick;

endmodule
`default_nettype wire

// File: tb/tb_controlador_estados.sv
`default_nettype none
// ============================================================================
// tb_controlador_estados : directed bench with behavioural model, two DUTs
// Rev 1.0
// ============================================================================
module tb_controlador_estados;

  localparam int T  = 4;
  localparam int CT = 8;
  localparam int AT = 7;
  localparam int GF = 5;
  localparam int GS = 4;
  localparam int GH = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controlador_estados_if ifa ();
  controlador_estados_if ifb ();

  controlador_estados #(
    .TICK_CYCLES(T), .INIT_STAT(50), .COMENDO_TICKS(CT), .AULA_TICKS(AT),
    .GANHO_FOME(GF), .GANHO_SONO(GS), .GANHO_FELIC(GH)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  controlador_estados #(
    .TICK_CYCLES(T), .INIT_STAT(2), .COMENDO_TICKS(CT), .AULA_TICKS(AT),
    .GANHO_FOME(GF), .GANHO_SONO(GS), .GANHO_FELIC(GH)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: st holds the visible estado code, cnt counts edges since reset.
  typedef struct packed {
    int st;
    int fel;
    int fom;
    int son;
    int dur;
    int cnt;
  } mdl_t;

  function automatic int clamp(input int x);
    return (x < 0) ? 0 : ((x > 100) ? 100 : x);
  endfunction

  function automatic bit mdl_tick(input mdl_t m);
    return (m.cnt > 0) && (m.cnt % T == 0);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit rst, input bit c,
                                    input bit d, input bit a, input int init);
    mdl_t n;
    bit   tk;
    n = m;
    if (rst) begin
      n.st = 0; n.fel = init; n.fom = init; n.son = init; n.dur = 0; n.cnt = 0;
      return n;
    end
    tk    = mdl_tick(m);
    n.cnt = m.cnt + 1;
    if (m.st == 8) return n;
    if (tk) begin
      if (m.st == 0)      begin n.fom = clamp(m.fom - 1);  n.son = clamp(m.son - 1);  n.fel = clamp(m.fel - 1);  end
      else if (m.st == 2) begin n.fom = clamp(m.fom + GF); n.fel = clamp(m.fel + 1); end
      else if (m.st == 1) begin n.son = clamp(m.son + GS); n.fom = clamp(m.fom - 1); end
      else if (m.st == 4) begin n.fel = clamp(m.fel + GH); n.fom = clamp(m.fom - 2);  n.son = clamp(m.son - 2);  end
    end
    if (tk && (n.fom == 0 || n.son == 0)) n.st = 8;
    else begin
      if (tk && (m.st == 2 || m.st == 4)) n.dur = m.dur + 1;
      if (m.st == 2 && n.dur == CT)                         n.st = 0;
      else if (m.st == 4 && n.dur == AT)                    n.st = 0;
      else if (m.st == 1 && ((tk && n.son == 100) || d))    n.st = 0;
      else if (m.st == 0)                                   n.st = c ? 2 : (d ? 1 : (a ? 4 : 0));
    end
    if (n.st != m.st) n.dur = 0;
    return n;
  endfunction

  mdl_t ma, mb;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    ma = mdl_step(ma, reset, ifa.btn_comer, ifa.btn_dormir, ifa.btn_aula, 50);
    mb = mdl_step(mb, reset, ifb.btn_comer, ifb.btn_dormir, ifb.btn_aula, 2);
    if (reset) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("a_estado", int'(ifa.estado),     ma.st);
      check("a_felic",  int'(ifa.felicidade), ma.fel);
      check("a_fome",   int'(ifa.fome),       ma.fom);
      check("a_sono",   int'(ifa.sono),       ma.son);
      check("a_tick",   int'(ifa.tick),       int'(mdl_tick(ma)));
      check("b_estado", int'(ifb.estado),     mb.st);
      check("b_felic",  int'(ifb.felicidade), mb.fel);
      check("b_fome",   int'(ifb.fome),       mb.fom);
      check("b_sono",   int'(ifb.sono),       mb.son);
      check("b_tick",   int'(ifb.tick),       int'(mdl_tick(mb)));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tick_a(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.tick && k < 3 * T);
    if (!ifa.tick) begin
      n_checks++;
      $display("FAIL wait_tick_a: no tick within %0d cycles", 3 * T);
    end
  endtask

  task automatic wait_tick_b();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!ifb.tick && k < 3 * T);
    if (!ifb.tick) begin
      n_checks++;
      $display("FAIL wait_tick_b: no tick within %0d cycles", 3 * T);
    end
  endtask

  task automatic ticks_a(input int n);
    int k;
    for (int i = 0; i < n; i++) wait_tick_a(k);
  endtask

  task automatic pulse_a(input bit c, input bit d, input bit a);
    ifa.btn_comer = c; ifa.btn_dormir = d; ifa.btn_aula = a;
    @(negedge clk);
    ifa.btn_comer = 1'b0; ifa.btn_dormir = 1'b0; ifa.btn_aula = 1'b0;
  endtask

  task automatic pulse_b(input bit c, input bit d, input bit a);
    ifb.btn_comer = c; ifb.btn_dormir = d; ifb.btn_aula = a;
    @(negedge clk);
    ifb.btn_comer = 1'b0; ifb.btn_dormir = 1'b0; ifb.btn_aula = 1'b0;
  endtask

  task automatic lit_a(input string name, input int e, input int fe, input int fo, input int so);
    check({name, "_estado"}, int'(ifa.estado),     e);
    check({name, "_felic"},  int'(ifa.felicidade), fe);
    check({name, "_fome"},   int'(ifa.fome),       fo);
    check({name, "_sono"},   int'(ifa.sono),       so);
  endtask

  task automatic lit_b(input string name, input int e, input int fe, input int fo, input int so);
    check({name, "_estado"}, int'(ifb.estado),     e);
    check({name, "_felic"},  int'(ifb.felicidade), fe);
    check({name, "_fome"},   int'(ifb.fome),       fo);
    check({name, "_sono"},   int'(ifb.sono),       so);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    ifa.btn_comer = 1'b0; ifa.btn_dormir = 1'b0; ifa.btn_aula = 1'b0;
    ifb.btn_comer = 1'b0; ifb.btn_dormir = 1'b0; ifb.btn_aula = 1'b0;
    repeat (2) @(negedge clk);
    lit_a("rst", 0, 50, 50, 50);
    check("rst_tick", int'(ifa.tick), 0);
    reset = 1'b0;

    // Idle decay over 10 ticks, tick period pinned at T
    for (int i = 0; i < 10; i++) begin
      wait_tick_a(k);
      check("tick_period", k, T);
    end
    @(negedge clk);
    lit_a("idle10", 0, 40, 40, 40);

    // Feeding from a fresh reset
    do_reset();
    pulse_a(1'b1, 1'b0, 1'b0);
    check("comer_enter", int'(ifa.estado), 2);
    ticks_a(7);
    @(negedge clk);
    check("comer_7", int'(ifa.estado), 2);
    ticks_a(1);
    @(negedge clk);
    lit_a("comer_done", 0, 58, 90, 50);

    // Button coincident with a tick: idle rule applies, then feeding
    do_reset();
    wait_tick_a(k);
    pulse_a(1'b1, 1'b0, 1'b0);
    lit_a("coinc_enter", 2, 49, 49, 49);
    ticks_a(8);
    @(negedge clk);
    lit_a("coinc_done", 0, 57, 89, 49);

    // Sleep until sono saturates
    do_reset();
    pulse_a(1'b0, 1'b1, 1'b0);
    check("dormir_enter", int'(ifa.estado), 1);
    ticks_a(12);
    @(negedge clk);
    lit_a("dormir_12", 1, 50, 38, 98);
    ticks_a(1);
    @(negedge clk);
    lit_a("dormir_sat", 0, 50, 37, 100);

    // Wake by second btn_dormir
    do_reset();
    pulse_a(1'b0, 1'b1, 1'b0);
    ticks_a(3);
    @(negedge clk);
    check("wake_sono", int'(ifa.sono), 62);
    pulse_a(1'b0, 1'b1, 1'b0);
    lit_a("wake", 0, 50, 47, 62);

    // comer beats aula; aula ignored while eating
    do_reset();
    pulse_a(1'b1, 1'b0, 1'b1);
    check("prio_comer", int'(ifa.estado), 2);
    ticks_a(2);
    @(negedge clk);
    pulse_a(1'b0, 1'b0, 1'b1);
    check("aula_ignored", int'(ifa.estado), 2);
    ticks_a(6);
    @(negedge clk);
    lit_a("prio_done", 0, 58, 90, 50);

    // Death on DUT B (INIT_STAT=2)
    do_reset();
    lit_b("b_rst", 0, 2, 2, 2);
    pulse_b(1'b0, 1'b0, 1'b1);
    check("b_aula_enter", int'(ifb.estado), 4);
    wait_tick_b();
    @(negedge clk);
    lit_b("b_dead", 8, 8, 0, 0);
    pulse_b(1'b1, 1'b1, 1'b1);
    wait_tick_b();
    wait_tick_b();
    @(negedge clk);
    lit_b("b_dead_hold", 8, 8, 0, 0);
    do_reset();
    lit_b("b_rerst", 0, 2, 2, 2);

    // Reset in the middle of DANDO_AULA, coincident with a tick
    do_reset();
    pulse_a(1'b0, 1'b0, 1'b1);
    check("aula_enter", int'(ifa.estado), 4);
    ticks_a(2);
    wait_tick_a(k);
    reset = 1'b1;
    @(negedge clk);
    lit_a("midrst", 0, 50, 50, 50);
    check("midrst_tick", int'(ifa.tick), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_notick", int'(ifa.tick), 0);
    end
    @(negedge clk);
    check("midrst_first_tick", int'(ifa.tick), 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_estados.md
Name: controlador_estados

Overview:
- Game-state scheduler for the pet.
- Owns the three stats (felicidade, fome, sono) and the one-hot `estado` that drives the image controller's frame selection and status bars.
- Consumes debounced one-cycle button pulses, advances the stats on a slow game tick, and decides state transitions including death.
- Sits between the button front-end and the image controller / display path.

Parameters:
- TICK_CYCLES, 12_000_000, clk cycles per game tick (≥2).
- INIT_STAT, 50, reset value of all three stats (0..100).
- COMENDO_TICKS, 8, ticks spent in COMENDO.
- AULA_TICKS, 7, ticks spent in DANDO_AULA.
- GANHO_FOME, 5, fome gain per tick while COMENDO.
- GANHO_SONO, 4, sono gain per tick while DORMINDO.
- GANHO_FELIC, 6, felicidade gain per tick while DANDO_AULA.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_comer  in  1  one-cycle pulse, feed request.
- btn_dormir  in  1  one-cycle pulse, sleep/wake request.
- btn_aula  in  1  one-cycle pulse, lecture request.
- estado  out  4  IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- felicidade  out  8  0..100.
- fome  out  8  0..100 (100 = fully fed).
- sono  out  8  0..100 (100 = fully rested).
- tick  out  1  one-cycle game-tick pulse.

Behaviour:
- All outputs are registered.
- Reset values: estado=IDLE, all stats=INIT_STAT, tick=0, tick counter=0, duration counter=0.
- Tick generation:
  - Counter runs 0..TICK_CYCLES-1 and wraps to 0.
  - `tick` is 1 for exactly the cycle after the counter equals TICK_CYCLES-1, so the first tick after reset is at cycle TICK_CYCLES.
  - The counter runs in every state.
- Stat arithmetic:
  - 8-bit saturating; additions are computed 9-bit wide and clamped to 100.
  - Subtractions clamp at 0; values never leave 0..100.
- Per-tick stat updates, by current state:
  - IDLE: fome-1, sono-1, felicidade-1.
  - COMENDO: fome+GANHO_FOME, felicidade+1.
  - DORMINDO: sono+GANHO_SONO, fome-1.
  - DANDO_AULA: felicidade+GANHO_FELIC, fome-2, sono-2.
  - MORTO: no change.
- Transitions:
  - IDLE: btn_comer→COMENDO, else btn_dormir→DORMINDO, else btn_aula→DANDO_AULA. Priority is comer>dormir>aula when pulses coincide.
  - COMENDO: after COMENDO_TICKS ticks → IDLE. Buttons are ignored.
  - DANDO_AULA: after AULA_TICKS ticks → IDLE. Buttons are ignored.
  - DORMINDO: → IDLE on the tick where the updated sono reaches 100, or on btn_dormir (wake). btn_comer and btn_aula are ignored.
  - MORTO: absorbing; all buttons are ignored; only reset exits.
- Duration counter:
  - Cleared on every state entry; incremented on each tick in COMENDO and DANDO_AULA.
  - Exit occurs on the tick where the count reaches N, so the state spends exactly N ticks.
- Death:
  - Evaluated on every tick using the post-update values: if fome==0 or sono==0, estado becomes MORTO at the same edge as the stat update.
  - Death has priority over duration expiry, wake, and any button in that cycle.
- Button and tick in the same cycle (no death):
  - The tick's stat update uses the old state's rule.
  - estado changes at the same edge, and the duration counter clears.
  - Ticks for the new state start counting from the next tick.
- Button transitions take effect at the next clk edge (1-cycle latency); stats do not change on a button alone.
- Reset mid-operation: everything returns to reset values at the next edge, regardless of state or tick phase.

Decomposition:
- Package tamagotchi_pkg:
  - estado encodings IDLE/DORMINDO/COMENDO/DANDO_AULA/MORTO, shared with the image controller.
  - STAT_MAX=100.
  - Saturating add/sub functions.
- Sub-module gerador_tick:
  - Parameter TICK_CYCLES; ports clk, reset, tick.
  - Reused for the animation frame cadence.

Test Plan (TICK_CYCLES=4, INIT_STAT=50):
- Reset, idle 10 ticks → all stats 40, estado stays 0000, tick pulses every 4 cycles.
- btn_comer in IDLE → estado 0010 next cycle. After 8 ticks: fome=50+40=90, felicidade=58, estado back to 0000 on the 8th tick.
- btn_dormir, then run until sono saturates → sono gains 4/tick (50,54,…,98,100, never 102); estado returns to 0000 on the tick sono hits 100. A separate run with a second btn_dormir mid-sleep → immediate 0000.
- btn_comer and btn_aula in the same cycle → 0010 (comer wins). btn_aula while in COMENDO → ignored, state duration unchanged.
- INIT_STAT=2, btn_aula → after 1 tick fome=sono=0, estado=1000. Then all buttons and further ticks produce no change. Reset → 0000, stats=2.
- Assert reset in the middle of DANDO_AULA and coincident with a tick → next edge: estado 0000, stats INIT_STAT, tick=0, first tick 4 cycles later.
